// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction-fetch stage: the fetch FSM state
// encoding, the reset PC, the NOP instruction shown on an empty IF/ID slot,
// the PC width, and a helper that converts a byte PC into a word address.
package fetch_pkg;

  localparam int PC_W = 32;

  // PC loaded on reset; must be word aligned.
  localparam logic [PC_W-1:0] RESET_PC = 32'h0000_0000;

  // addi x0,x0,0 -- shown on id_ins whenever the IF/ID slot is empty.
  localparam logic [31:0] NOP_INS = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // The instruction cache is word addressed, so the byte offset bits are dropped.
  function automatic logic [PC_W-1:0] word_addr(input logic [PC_W-1:0] byte_pc);
    return {2'b00, byte_pc[PC_W-1:2]};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if
// Bundles the fetch stage's bus signals: the instruction-cache read port,
// the IF/ID valid/ready handshake toward decode, and the redirect/halt
// controls coming back from later stages.
//   master : the fetch unit (drives i_addr, id_*, halted, misalign)
//   slave  : the environment (cache + decode + control)
interface fetch_if;
  import fetch_pkg::*;

  logic [PC_W-1:0] i_addr;
  logic [31:0]     ins;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_ins;
  logic [PC_W-1:0] id_pc;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            halt_req;
  logic            halted;
  logic            misalign;

  modport master (
    output i_addr, id_valid, id_ins, id_pc, halted, misalign,
    input  ins, id_ready, redirect_valid, redirect_pc, halt_req
  );

  modport slave (
    input  i_addr, id_valid, id_ins, id_pc, halted, misalign,
    output ins, id_ready, redirect_valid, redirect_pc, halt_req
  );

endinterface

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen
// Program counter register and its next-PC selection.
// Ports:
//   clk, rst  : clock and synchronous active-high reset (pc <= RESET_PC)
//   load      : take load_pc as the new pc (redirect)
//   load_pc   : byte target; the two offset bits are dropped so pc stays aligned
//   advance   : step pc by one word (wraps modulo 2^32)
//   pc        : current byte PC
module fetch_pc_gen
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [PC_W-1:0] load_pc,
  input  logic            advance,
  output logic [PC_W-1:0] pc
);

  // Offset bits of a redirect target never reach the cache, so they are
  // deliberately discarded here.
  logic unused_load_bits;
  assign unused_load_bits = ^load_pc[1:0];

  // Redirect wins over sequential advance; otherwise the pc holds (stall/halt).
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= {load_pc[PC_W-1:2], 2'b00};
    end else if (advance) begin
      pc <= pc + PC_W'(4);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch stage. Holds the PC (in fetch_pc_gen), presents its word
// address to the instruction cache, captures the returned word with its PC
// into the IF/ID register and hands it to decode over valid/ready.
// Supports stall, redirect with flush, and halt.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : fetch_if.master (i_addr/ins, id_valid/id_ready/id_ins/id_pc,
//              redirect_valid/redirect_pc, halt_req, halted, misalign)
// Configuration:
//   FETCH_MISALIGN_EN : when defined, a redirect to a non-word-aligned target
//                       sets the sticky misalign flag and halts fetch instead
//                       of fetching it. When undefined, misalign is 0 and the
//                       offset bits are silently dropped.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  fetch_state_t    state, state_next;
  logic            id_valid_q, valid_next;
  logic [31:0]     id_ins_q;
  logic [PC_W-1:0] id_pc_q;
  logic            halted_q;
  logic [PC_W-1:0] pc;
  logic            pc_load, pc_adv, capture;
  logic            misalign_set;
  logic            bad_target;

`ifdef FETCH_MISALIGN_EN
  assign bad_target = (bus.redirect_pc[1:0] != 2'b00);
`else
  assign bad_target = 1'b0;
`endif

  fetch_pc_gen u_pc_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (pc_load),
    .load_pc (bus.redirect_pc),
    .advance (pc_adv),
    .pc      (pc)
  );

  // Next-state and datapath control. Within RUN the priority is
  // redirect > halt > capture > stall.
  always_comb begin
    state_next   = state;
    valid_next   = id_valid_q;
    capture      = 1'b0;
    pc_load      = 1'b0;
    pc_adv       = 1'b0;
    misalign_set = 1'b0;
    case (state)
      BOOT: begin
        // One idle cycle after reset so instruction memory can settle.
        state_next = RUN;
      end
      RUN: begin
        if (bus.redirect_valid) begin
          valid_next = 1'b0;
          if (bad_target) begin
            misalign_set = 1'b1;
            state_next   = HALT;
          end else begin
            pc_load = 1'b1;
          end
        end else if (bus.halt_req) begin
          state_next = HALT;
          if (bus.id_ready) valid_next = 1'b0;
        end else if (!id_valid_q || bus.id_ready) begin
          capture    = 1'b1;
          valid_next = 1'b1;
          pc_adv     = 1'b1;
        end
      end
      HALT: begin
        if (bus.redirect_valid) begin
          valid_next = 1'b0;
          if (bad_target) begin
            misalign_set = 1'b1;
          end else begin
            pc_load    = 1'b1;
            state_next = RUN;
          end
        end else if (bus.id_ready) begin
          // The last captured instruction drains once, then the slot stays empty.
          valid_next = 1'b0;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  // FSM state and the IF/ID register. halted mirrors the registered state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      id_valid_q <= 1'b0;
      id_ins_q   <= NOP_INS;
      id_pc_q    <= RESET_PC;
      halted_q   <= 1'b0;
    end else begin
      state      <= state_next;
      id_valid_q <= valid_next;
      halted_q   <= (state_next == HALT);
      if (capture) begin
        id_ins_q <= bus.ins;
        id_pc_q  <= pc;
      end
    end
  end

`ifdef FETCH_MISALIGN_EN
  logic misalign_q;

  // Sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (misalign_set) begin
      misalign_q <= 1'b1;
    end
  end

  assign bus.misalign = misalign_q;
`else
  logic unused_misalign_set;
  assign unused_misalign_set = misalign_set;
  assign bus.misalign        = 1'b0;
`endif

  assign bus.i_addr   = word_addr(pc);
  assign bus.id_valid = id_valid_q;
  assign bus.id_ins   = id_valid_q ? id_ins_q : NOP_INS;
  assign bus.id_pc    = id_pc_q;
  assign bus.halted   = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed bench for fetch_unit. The instruction memory is a simple function
// of the word address, so each expected id_ins follows from the expected id_pc.
// Inputs change 1ns after a rising edge; outputs are sampled at that point.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;

  fetch_if bus ();

  fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: tag byte plus low address bits.
  function automatic logic [31:0] memWord(input logic [31:0] waddr);
    return {8'hC3, waddr[23:0]};
  endfunction

  assign bus.ins = memWord(bus.i_addr);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Set the inputs for the coming edge, clock once, then settle 1ns.
  task automatic applyStimulus(input logic rstV, input logic readyV, input logic rvV,
                               input logic [31:0] rpcV, input logic haltV);
    rst                = rstV;
    bus.id_ready       = readyV;
    bus.redirect_valid = rvV;
    bus.redirect_pc    = rpcV;
    bus.halt_req       = haltV;
    @(posedge clk);
    #1;
  endtask

  // Compare the IF/ID view against an expected slot and fetch address.
  task automatic checkSlot(input string tag, input logic expValid,
                           input logic [31:0] expPc, input logic [31:0] expIaddr);
    checkOutput({tag, ".valid"}, {31'd0, bus.id_valid}, {31'd0, expValid});
    checkOutput({tag, ".ins"}, bus.id_ins, expValid ? memWord(expPc >> 2) : NOP_INS);
    if (expValid) checkOutput({tag, ".pc"}, bus.id_pc, expPc);
    checkOutput({tag, ".iaddr"}, bus.i_addr, expIaddr);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst                = 1'b1;
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.halt_req       = 1'b0;
    #1;

    // Reset state
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checkSlot("reset", 1'b0, 32'h0, 32'h0);
    checkOutput("reset.pc", bus.id_pc, 32'h0);
    checkOutput("reset.halted", {31'd0, bus.halted}, 32'd0);
    checkOutput("reset.misalign", {31'd0, bus.misalign}, 32'd0);

    // BOOT cycle, then one instruction per cycle
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkSlot("boot", 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      checkSlot($sformatf("seq%0d", i), 1'b1, 32'(i * 4), 32'(i + 1));
    end

    // Stall three cycles holding id_pc=8
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      checkSlot($sformatf("stall%0d", i), 1'b1, 32'h8, 32'h3);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkSlot("resume", 1'b1, 32'hC, 32'h4);

    // Redirect while decode is stalled: flush, then target valid
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
    checkSlot("redir.flush", 1'b0, 32'h0, 32'h40);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkSlot("redir.target", 1'b1, 32'h100, 32'h41);

    // PC wrap at the top of the address space
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    checkSlot("wrap.flush", 1'b0, 32'h0, 32'h3FFF_FFFF);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkSlot("wrap.top", 1'b1, 32'hFFFF_FFFC, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkSlot("wrap.zero", 1'b1, 32'h0, 32'h1);

    // Halt with decode stalled: slot held, then drains once
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("halt.halted", {31'd0, bus.halted}, 32'd1);
    checkSlot("halt.hold", 1'b1, 32'h0, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkSlot("halt.hold2", 1'b1, 32'h0, 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkSlot("halt.drain", 1'b0, 32'h0, 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkSlot("halt.idle", 1'b0, 32'h0, 32'h1);
    checkOutput("halt.still", {31'd0, bus.halted}, 32'd1);

    // Redirect out of HALT
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h20, 1'b0);
    checkOutput("unhalt.halted", {31'd0, bus.halted}, 32'd0);
    checkSlot("unhalt.flush", 1'b0, 32'h0, 32'h8);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkSlot("unhalt.target", 1'b1, 32'h20, 32'h9);

    // Misaligned redirect target
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h102, 1'b0);
`ifdef FETCH_MISALIGN_EN
    checkOutput("mis.flag", {31'd0, bus.misalign}, 32'd1);
    checkOutput("mis.halted", {31'd0, bus.halted}, 32'd1);
    checkOutput("mis.valid", {31'd0, bus.id_valid}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("mis.sticky", {31'd0, bus.misalign}, 32'd1);
    checkOutput("mis.valid2", {31'd0, bus.id_valid}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("mis.rstflag", {31'd0, bus.misalign}, 32'd0);
    checkOutput("mis.rsthalt", {31'd0, bus.halted}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
`else
    checkOutput("mis.flag", {31'd0, bus.misalign}, 32'd0);
    checkSlot("mis.flush", 1'b0, 32'h0, 32'h40);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkSlot("mis.target", 1'b1, 32'h100, 32'h41);
`endif

    // Reset during a stalled redirect overrides everything
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h200, 1'b0);
    checkSlot("rstover", 1'b0, 32'h0, 32'h0);
    checkOutput("rstover.pc", bus.id_pc, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkSlot("rstover.first", 1'b1, 32'h0, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
